rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that shares a single resource and drives a one-hot grant. It sits in front of the 2:4 decoder datapath: the arbiter owns the 2-bit winner index, and the one-hot `grant` is exactly `1 << grant_idx` while a grant is active. Requesters hold the resource until they signal `done` or drop their request.

---
 rtl/rr_arbiter_4.sv | 113 +++++++++++
 tb/tb_rr_arbiter_4.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a registered one-hot grant.
// A winner holds the resource until it pulses done or drops its request.
// The cycle after every release is spent in IDLE.
// Optional feature macro RR_ARB_TIMEOUT_EN: forced release after MAX_HOLD grant
// cycles, flagged by a one-cycle timeout pulse. Without the macro, timeout is 0.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [3:0] grant_q;
  logic [1:0] grant_idx_q;
  logic       busy_q;

  logic [1:0] win_idx_d;
  logic [1:0] cand;

  // Elaboration-time range check on the hold limit.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 1..255");
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;
  logic       timeout_q;
`endif

  // Pick the first asserted request starting at ptr_q; lowest offset wins.
  always_comb begin
    win_idx_d = ptr_q;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        win_idx_d = cand;
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 4'b0000;
      grant_idx_q <= 2'd0;
      busy_q      <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q     <= GRANT;
            grant_idx_q <= win_idx_d;
            grant_q     <= 4'b0001 << win_idx_d;
            busy_q      <= 1'b1;
            ptr_q       <= win_idx_d + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q      <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // A normal release always wins over expiry, so timeout stays low then.
          if (done || !req[grant_idx_q]) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (hold_q == HOLD_LAST) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: stimulus process drives inputs on the falling
// edge and queues the expected post-edge outputs from a behavioural model;
// a monitor pops and compares after every rising edge.
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_idx(grant_idx),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       b;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: owner is -1 when nobody holds the resource.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    exp_t e;
    int   c;
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 3; k >= 0; k--) begin
        c = (m_ptr + k) % 4;
        if (r[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_ptr  = (m_owner + 1) % 4;
        m_held = 0;
      end
    end else begin
      m_held = m_held + 1;
      if (d || !r[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && m_held >= MAX_HOLD) begin
        m_owner = -1;
        m_to    = 1'b1;
      end
    end
    e.g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.idx = 2'(m_last);
    e.b   = (m_owner >= 0);
    e.t   = m_to;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against queued expectations after each edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {grant, grant_idx, busy, timeout};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got grant=%b idx=%0d busy=%b to=%b want grant=%b idx=%0d busy=%b to=%b",
                   cyc, a.g, a.idx, a.b, a.t, e.g, e.idx, e.b, e.t);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    // reset
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    // single request, done release, idle after
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // done in IDLE ignored
    step(4'b0000, 1'b1, 1'b0);
    // all requesting from reset, done every cycle
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(4'b1111, 1'b1, 1'b0);
    // after requester 3 wins: 1001 wraps to 0 then 3
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b1111, (i % 2 == 1), 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b1001, (i % 2 == 1), 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // grant to 1, req[0] joins, 1 drops
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    // reset while requester 3 holds
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    // long hold: timeout with the macro, indefinite hold without
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(4'b0010, 1'b0, 1'b0);
    // done coinciding with expiry
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < MAX_HOLD; i++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // randomized traffic
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      step(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
